// File: rtl/key_pkg.sv
// Shared constants and types for the key event scheduler.
package key_pkg;
  localparam int unsigned LANES_DEF  = 4;
  localparam int unsigned TS_W_DEF   = 16;
  localparam int unsigned DROP_W_DEF = 8;

  localparam logic EVT_PRESS   = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted index.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_valid
);
  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned idx;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(idx);
        grant[idx]  = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (advance && grant_valid) begin
      ptr_d = IW'((32'(grant_idx) + 1) % N);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: rtl/key_event_scheduler.sv
// Serialises per-lane press/release pulses into one timestamped event stream
// with one pending slot per lane, round-robin selection and a valid/ready output.
module key_event_scheduler import key_pkg::*; #(
  parameter int unsigned LANES  = LANES_DEF,
  parameter int unsigned TS_W   = TS_W_DEF,
  parameter int unsigned DROP_W = DROP_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     enable,
  input  logic                     tick,
  input  logic [LANES-1:0]         press_pulse,
  input  logic [LANES-1:0]         release_pulse,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(LANES)-1:0] evt_lane,
  output logic                     evt_type,
  output logic [TS_W-1:0]          evt_time,
  output logic [DROP_W-1:0]        drop_count,
  output logic                     busy
);
  localparam int unsigned IW    = $clog2(LANES);
  localparam int unsigned SUM_W = $clog2(2 * LANES + 1);
  localparam int unsigned EXT_W = ((DROP_W > SUM_W) ? DROP_W : SUM_W) + 1;

  logic [TS_W-1:0]   ts_q, ts_d;
  logic [LANES-1:0]  slot_valid_q, slot_valid_d;
  logic [LANES-1:0]  slot_type_q, slot_type_d;
  logic [TS_W-1:0]   slot_time_q [LANES];
  logic [TS_W-1:0]   slot_time_d [LANES];
  out_state_e        state_q, state_d;
  logic [IW-1:0]     lane_q, lane_d;
  logic              type_q, type_d;
  logic [TS_W-1:0]   time_q, time_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [LANES-1:0]  grant;
  logic [IW-1:0]     grant_idx;
  logic              grant_valid;
  logic              load;
  logic [LANES-1:0]  slot_held;
  logic [SUM_W-1:0]  drop_sum;
  logic [EXT_W-1:0]  drop_ext;

  rr_arbiter #(.N(LANES)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .req         (slot_valid_q),
    .advance     (load),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Output register can take a new event when empty or being accepted this cycle.
  assign load      = grant_valid && ((state_q == EMPTY) || evt_ready);
  assign slot_held = load ? (slot_valid_q & ~grant) : slot_valid_q;

  always_comb begin
    ts_d = ts_q;
    if (clear) begin
      ts_d = '0;
    end else if (enable && tick) begin
      ts_d = ts_q + TS_W'(1);
    end
  end

  // A slot freed by this cycle's load can accept a new pulse without a drop.
  always_comb begin
    slot_valid_d = slot_held;
    slot_type_d  = slot_type_q;
    slot_time_d  = slot_time_q;
    drop_sum     = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (enable && (press_pulse[i] || release_pulse[i])) begin
        if (!slot_held[i]) begin
          slot_valid_d[i] = 1'b1;
          slot_type_d[i]  = press_pulse[i] ? EVT_PRESS : EVT_RELEASE;
          slot_time_d[i]  = ts_q;
          drop_sum        = drop_sum + SUM_W'(press_pulse[i] & release_pulse[i]);
        end else begin
          drop_sum = drop_sum + SUM_W'(press_pulse[i]) + SUM_W'(release_pulse[i]);
        end
      end
    end
    if (clear) begin
      slot_valid_d = '0;
      slot_type_d  = '0;
      slot_time_d  = '{default: '0};
    end
  end

  always_comb begin
    drop_ext = EXT_W'(drop_q) + EXT_W'(drop_sum);
    if (clear) begin
      drop_d = '0;
    end else if (drop_ext > EXT_W'({DROP_W{1'b1}})) begin
      drop_d = '1;
    end else begin
      drop_d = drop_ext[DROP_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    type_d  = type_q;
    time_d  = time_q;
    if (clear) begin
      state_d = EMPTY;
      lane_d  = '0;
      type_d  = 1'b0;
      time_d  = '0;
    end else if (load) begin
      state_d = FULL;
      lane_d  = grant_idx;
      type_d  = slot_type_q[grant_idx];
      time_d  = slot_time_q[grant_idx];
    end else if ((state_q == FULL) && evt_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q         <= '0;
      slot_valid_q <= '0;
      slot_type_q  <= '0;
      slot_time_q  <= '{default: '0};
      state_q      <= EMPTY;
      lane_q       <= '0;
      type_q       <= 1'b0;
      time_q       <= '0;
      drop_q       <= '0;
    end else begin
      ts_q         <= ts_d;
      slot_valid_q <= slot_valid_d;
      slot_type_q  <= slot_type_d;
      slot_time_q  <= slot_time_d;
      state_q      <= state_d;
      lane_q       <= lane_d;
      type_q       <= type_d;
      time_q       <= time_d;
      drop_q       <= drop_d;
    end
  end

  assign evt_valid  = (state_q == FULL);
  assign evt_lane   = lane_q;
  assign evt_type   = type_q;
  assign evt_time   = time_q;
  assign drop_count = drop_q;
  assign busy       = evt_valid | (|slot_valid_q);
endmodule

// File: tb/tb_key_event_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_key_event_scheduler;
  localparam int LANES = 4;

  logic       clk;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       enable = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] press = '0;
  logic [3:0] rel_pulse = '0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_lane;
  logic       evt_type;
  logic [15:0] evt_time;
  logic [7:0] drop_count;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  key_event_scheduler #(.LANES(4), .TS_W(16), .DROP_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .enable        (enable),
    .tick          (tick),
    .press_pulse   (press),
    .release_pulse (rel_pulse),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_lane      (evt_lane),
    .evt_type      (evt_type),
    .evt_time      (evt_time),
    .drop_count    (drop_count),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending events per lane, one output holding register.
  bit m_pend [LANES];
  bit m_ptype [LANES];
  int m_ptime [LANES];
  bit m_valid;
  int m_lane, m_type, m_time, m_ptr, m_ts, m_drop;

  task automatic m_reset();
    for (int l = 0; l < LANES; l++) begin
      m_pend[l] = 0; m_ptype[l] = 0; m_ptime[l] = 0;
    end
    m_valid = 0; m_lane = 0; m_type = 0; m_time = 0;
    m_ptr = 0; m_ts = 0; m_drop = 0;
  endtask

  task automatic m_step();
    int g;
    int d;
    bit freed [LANES];
    if (clear) begin
      m_reset();
      return;
    end
    g = -1;
    if (!m_valid || evt_ready) begin
      for (int k = 0; k < LANES; k++) begin
        int l;
        l = (m_ptr + k) % LANES;
        if (g < 0 && m_pend[l]) g = l;
      end
    end
    for (int l = 0; l < LANES; l++) freed[l] = !m_pend[l] || (l == g);
    if (g >= 0) begin
      m_valid = 1; m_lane = g; m_type = m_ptype[g]; m_time = m_ptime[g];
      m_pend[g] = 0;
      m_ptr = (g + 1) % LANES;
    end else if (m_valid && evt_ready) begin
      m_valid = 0;
    end
    if (enable) begin
      d = 0;
      for (int l = 0; l < LANES; l++) begin
        if (press[l] || rel_pulse[l]) begin
          if (freed[l]) begin
            m_pend[l] = 1; m_ptype[l] = press[l]; m_ptime[l] = m_ts;
            if (press[l] && rel_pulse[l]) d++;
          end else begin
            d += int'(press[l]) + int'(rel_pulse[l]);
          end
        end
      end
      m_drop = (m_drop + d > 255) ? 255 : m_drop + d;
      if (tick) m_ts = (m_ts + 1) % 65536;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) m_reset();
    else m_step();
  end

  always @(negedge clk) begin
    bit any;
    any = m_valid;
    for (int l = 0; l < LANES; l++) any = any | m_pend[l];
    chk("m_valid", 32'(evt_valid), 32'(m_valid));
    chk("m_busy", 32'(busy), 32'(any));
    chk("m_drop", 32'(drop_count), 32'(m_drop));
    if (m_valid) begin
      chk("m_lane", 32'(evt_lane), 32'(m_lane));
      chk("m_type", 32'(evt_type), 32'(m_type));
      chk("m_time", 32'(evt_time), 32'(m_time));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [3:0] p, input logic [3:0] r);
    press = p; rel_pulse = r;
    step(1);
    press = '0; rel_pulse = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  int q_lane[$];
  int q_time[$];
  int q_type[$];

  task automatic collect(input int n);
    q_lane.delete(); q_time.delete(); q_type.delete();
    repeat (n) begin
      if (evt_valid && evt_ready) begin
        q_lane.push_back(int'(evt_lane));
        q_time.push_back(int'(evt_time));
        q_type.push_back(int'(evt_type));
      end
      step(1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    step(2);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_drop", 32'(drop_count), 0);
    reset = 1'b0;
    enable = 1'b1;
    evt_ready = 1'b1;

    // 1: single press at ts=5, two-cycle latency
    do_clear();
    tick = 1'b1;
    step(5);
    tick = 1'b0;
    pulse(4'b0100, 4'b0000);
    chk("t1_latency", 32'(evt_valid), 0);
    step(1);
    chk("t1_valid", 32'(evt_valid), 1);
    chk("t1_lane", 32'(evt_lane), 2);
    chk("t1_type", 32'(evt_type), 1);
    chk("t1_time", 32'(evt_time), 5);

    // 2: round-robin order
    do_clear();
    pulse(4'b1011, 4'b0000);
    collect(5);
    chk("t2a_count", 32'(q_lane.size()), 3);
    if (q_lane.size() == 3) begin
      chk("t2a_0", 32'(q_lane[0]), 0);
      chk("t2a_1", 32'(q_lane[1]), 1);
      chk("t2a_2", 32'(q_lane[2]), 3);
    end
    pulse(4'b1001, 4'b0000);
    collect(4);
    chk("t2b_count", 32'(q_lane.size()), 2);
    if (q_lane.size() == 2) begin
      chk("t2b_0", 32'(q_lane[0]), 0);
      chk("t2b_1", 32'(q_lane[1]), 3);
    end

    // 3: backpressure, slot full -> drop, first timestamp delivered
    evt_ready = 1'b0;
    do_clear();
    tick = 1'b1;
    pulse(4'b0010, 4'b0000);
    step(3);
    pulse(4'b0010, 4'b0000);
    step(3);
    pulse(4'b0010, 4'b0000);
    tick = 1'b0;
    chk("t3_drop", 32'(drop_count), 1);
    chk("t3_valid", 32'(evt_valid), 1);
    chk("t3_time", 32'(evt_time), 0);
    step(2);
    chk("t3_hold", 32'(evt_time), 0);
    evt_ready = 1'b1;
    collect(4);
    chk("t3_count", 32'(q_time.size()), 2);
    if (q_time.size() == 2) begin
      chk("t3_first", 32'(q_time[0]), 0);
      chk("t3_second", 32'(q_time[1]), 4);
    end

    // 4: press+release same cycle, then drop saturation
    do_clear();
    pulse(4'b0001, 4'b0001);
    collect(3);
    chk("t4_count", 32'(q_lane.size()), 1);
    if (q_lane.size() == 1) chk("t4_type", 32'(q_type[0]), 1);
    chk("t4_drop", 32'(drop_count), 1);
    evt_ready = 1'b0;
    press = 4'b1111; rel_pulse = 4'b1111;
    step(40);
    press = '0; rel_pulse = '0;
    chk("t4_sat", 32'(drop_count), 255);
    evt_ready = 1'b1;

    // 5: timestamp wrap and enable=0
    do_clear();
    tick = 1'b1;
    step(65535);
    pulse(4'b0001, 4'b0000);
    pulse(4'b0010, 4'b0000);
    tick = 1'b0;
    collect(4);
    chk("t5_count", 32'(q_time.size()), 2);
    if (q_time.size() == 2) begin
      chk("t5_ffff", 32'(q_time[0]), 32'h0000_ffff);
      chk("t5_wrap", 32'(q_time[1]), 0);
    end
    enable = 1'b0;
    tick = 1'b1;
    repeat (3) pulse(4'b1111, 4'b1111);
    step(2);
    chk("t5_dis_valid", 32'(evt_valid), 0);
    chk("t5_dis_busy", 32'(busy), 0);
    chk("t5_dis_drop", 32'(drop_count), 0);
    enable = 1'b1;
    tick = 1'b0;
    pulse(4'b0100, 4'b0000);
    collect(3);
    chk("t5_frz_count", 32'(q_time.size()), 1);
    if (q_time.size() == 1) chk("t5_frozen", 32'(q_time[0]), 1);

    // 6: reset and clear with events in flight
    do_clear();
    evt_ready = 1'b0;
    pulse(4'b1111, 4'b0000);
    step(2);
    chk("t6_pre_valid", 32'(evt_valid), 1);
    reset = 1'b1;
    step(1);
    chk("t6_rst_valid", 32'(evt_valid), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_time", 32'(evt_time), 0);
    reset = 1'b0;
    evt_ready = 1'b1;
    collect(5);
    chk("t6_rst_stale", 32'(q_lane.size()), 0);
    evt_ready = 1'b0;
    pulse(4'b1111, 4'b0000);
    step(2);
    clear = 1'b1; evt_ready = 1'b1;
    step(1);
    clear = 1'b0;
    chk("t6_clr_valid", 32'(evt_valid), 0);
    chk("t6_clr_busy", 32'(busy), 0);
    collect(5);
    chk("t6_clr_stale", 32'(q_lane.size()), 0);

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      enable    = ($urandom % 8) != 0;
      tick      = $urandom % 2;
      press     = 4'($urandom & $urandom);
      rel_pulse = 4'($urandom & $urandom);
      evt_ready = ($urandom % 4) != 0;
      clear     = ($urandom % 200) == 0;
      step(1);
    end
    press = '0; rel_pulse = '0; clear = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
